pulser_multi: RTL and testbench
===============================

Name: pulser_multi

Overview:
- Multi-channel "breathing" LED driver; next generation of the single-channel pulser.
- One shared free-running PWM counter drives CHANNELS duty-cycle generators, each with a fixed phase offset so LEDs ripple rather than pulse in unison.
- Selectable waveform mode (triangle, sawtooth, hold) and run-time dwell time.
- Sits between board-level control/status logic and the LED pins.

Parameters:
- CHANNELS, 4: number of PWM outputs; 1..16.
- WIDTH, 8: duty and PWM counter width; MAX = 2^WIDTH-1.
- DWELL_W, 10: width of the dwell input and dwell counter.
- START, 1: channel 0 duty after reset/restart.
- PHASE, 64: duty offset per channel; channel i starts at (START + i*PHASE) mod 2^WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = run; 0 = freeze all state, outputs low.
- restart  in  1  single-cycle pulse; reload start values.
- mode  in  2  00 triangle, 01 sawtooth, 10 hold, 11 reserved (treated as hold).
- dwell  in  DWELL_W  extra PWM periods per duty step; 0 = step every period.
- hold_level  in  WIDTH  duty applied to all channels in hold mode.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse on the last cycle of each PWM period.
- step  out  1  one-cycle pulse when duty values advance.

Behaviour:
- Reset (rst_n=0 at clk edge): cnt=0, dwell_cnt=0, duty[i]=(START+i*PHASE) mod 2^WIDTH, dir[i]=up, pwm_out=0, period_tick=0, step=0. rst_n overrides every other input.
- PWM counter: when enable=1, cnt increments by 1 each cycle and wraps MAX->0.
- period_tick (combinational) = enable & (cnt==MAX).
- pwm_out[i] is registered: next value = enable & (cnt < duty[i]).
  - Latency: 1 cycle after cnt.
  - duty=0 gives a constant low output.
  - duty=MAX gives high for MAX of 2^WIDTH cycles.
- Dwell:
  - step (combinational) = period_tick & (dwell_cnt==dwell).
  - On step, dwell_cnt<=0; otherwise dwell_cnt += period_tick.
  - If dwell is lowered below dwell_cnt, dwell_cnt counts up, wraps at 2^DWELL_W, and then steps. This is allowed; software must change dwell only while enable=0.
- Duty update on step, per channel, by mode sampled in the same cycle:
  - Triangle:
    - dir up & duty==MAX: dir<=down, duty<=MAX-1.
    - dir down & duty==0: dir<=up, duty<=1.
    - Otherwise duty +/-1 per dir.
    - No endpoint value repeats. Full cycle is 2*MAX steps.
  - Sawtooth: duty<=duty+1, wrapping MAX->0. dir unchanged.
  - Hold/reserved: duty<=hold_level and dir unchanged. hold_level is also loaded on every cycle while in hold mode and enable=1, so it takes effect without waiting for a step.
- Leaving hold for triangle: continue from hold_level with the retained dir. If retained dir=up and duty==MAX, the next step bounces.
- restart=1 (with enable=x): same state load as reset except the registered pwm_out, which follows the normal rule. restart beats a coincident step.
- enable=0: cnt, dwell_cnt, duty and dir are frozen. period_tick=0, step=0. pwm_out goes 0 on the next edge. Re-enable resumes from the frozen cnt.
- Mode changes outside step events do not alter duty, except for the hold-mode continuous load.
- All arithmetic is modulo 2^WIDTH or 2^DWELL_W. No state is left uninitialised after reset.

Test Plan:
- Test configuration: WIDTH=4, CHANNELS=2, START=1, PHASE=8.
- Reset, enable=1, mode=triangle, dwell=0:
  - ch0 duty sequence per period is 1,2,...,15,14,...,0,1.
  - ch1 starts at 9.
  - pwm_out[0] high exactly duty cycles of every 16.
  - period_tick every 16 clocks.
- dwell=2, triangle: step fires every 3rd period_tick (48 clocks). pwm_out duty is constant between steps.
- mode=sawtooth from duty 14: ch0 steps 14,15,0,1. At duty 0, pwm_out[0] stays low for the whole period.
- mode=hold, hold_level=5 mid-period:
  - Both channels' duty becomes 5 on the next clock, with no step required.
  - Then mode=triangle: ch0 continues 6,7,... (dir up retained).
- enable=0 for 37 cycles mid-period:
  - pwm_out=0 one cycle later; period_tick and step stay 0.
  - On re-enable, cnt and duty resume at their frozen values.
- restart coincident with step; then separately rst_n=0 during active PWM:
  - restart: duties reload 1 and 9, dir up, cnt=0 (no step applied).
  - rst_n: all outputs 0 on the next edge, and state equals the reset values.

Source files
------------

// File: rtl/pulser_multi.sv
// Multi-channel breathing LED driver: one shared PWM counter, per-channel
// phase-offset duty generators with triangle, sawtooth and hold waveforms.
module pulser_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DWELL_W  = 10,
    parameter int START    = 1,
    parameter int PHASE    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                restart,
    input  logic [1:0]          mode,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [WIDTH-1:0]    hold_level,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic                step
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        M_TRI  = 2'b00,
        M_SAW  = 2'b01,
        M_HOLD = 2'b10,
        M_RSV  = 2'b11
    } mode_t;

    function automatic logic [WIDTH-1:0] start_duty(input int ch);
        int s;
        s = START + ch * PHASE;
        return s[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0]    r_cnt;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [WIDTH-1:0]    r_duty [CHANNELS];
    logic [CHANNELS-1:0] r_dn;
    logic [CHANNELS-1:0] r_pwm;

    logic                w_period_tick;
    logic                w_step;
    logic                w_hold;
    mode_t               w_mode;
    logic [WIDTH-1:0]    w_duty_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_dn_nxt;
    logic [CHANNELS-1:0] w_pwm_nxt;
    logic [DWELL_W-1:0]  w_dwell_nxt;

    assign w_mode        = mode_t'(mode);
    assign w_hold        = (w_mode == M_HOLD) || (w_mode == M_RSV);
    assign w_period_tick = enable && (r_cnt == MAX);
    assign w_step        = w_period_tick && (r_dwell_cnt == dwell);

    assign period_tick = w_period_tick;
    assign step        = w_step;
    assign pwm_out     = r_pwm;

    always_comb begin
        if (w_step) begin
            w_dwell_nxt = '0;
        end else begin
            w_dwell_nxt = r_dwell_cnt
                        + {{(DWELL_W-1){1'b0}}, w_period_tick};
        end
    end

    // Hold loads hold_level every enabled cycle, step or not.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_duty_nxt[i] = r_duty[i];
            w_dn_nxt[i]   = r_dn[i];
            w_pwm_nxt[i]  = enable && (r_cnt < r_duty[i]);
            if (w_hold) begin
                w_duty_nxt[i] = hold_level;
            end else if (w_step) begin
                case (w_mode)
                    M_TRI: begin
                        if (!r_dn[i] && (r_duty[i] == MAX)) begin
                            w_dn_nxt[i]   = 1'b1;
                            w_duty_nxt[i] = MAX - ONE;
                        end else if (r_dn[i] && (r_duty[i] == '0)) begin
                            w_dn_nxt[i]   = 1'b0;
                            w_duty_nxt[i] = ONE;
                        end else if (r_dn[i]) begin
                            w_duty_nxt[i] = r_duty[i] - ONE;
                        end else begin
                            w_duty_nxt[i] = r_duty[i] + ONE;
                        end
                    end
                    M_SAW: begin
                        w_duty_nxt[i] = r_duty[i] + ONE;
                    end
                    default: begin
                        w_duty_nxt[i] = hold_level;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dwell_cnt <= '0;
            r_dn        <= '0;
            r_pwm       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= start_duty(i);
            end
        end else begin
            r_pwm <= w_pwm_nxt;
            if (restart) begin
                r_cnt       <= '0;
                r_dwell_cnt <= '0;
                r_dn        <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty[i] <= start_duty(i);
                end
            end else if (enable) begin
                r_cnt       <= r_cnt + ONE;
                r_dwell_cnt <= w_dwell_nxt;
                r_dn        <= w_dn_nxt;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty[i] <= w_duty_nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pulser_multi.sv
// Bench for pulser_multi: directed scenarios plus random stimulus,
// every cycle checked against a behavioural waveform model.
module tb_pulser_multi;

    localparam int CH   = 2;
    localparam int W    = 4;
    localparam int DW   = 10;
    localparam int ST   = 1;
    localparam int PH   = 8;
    localparam int MAXV = 15;
    localparam int MOD  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          restart;
    logic [1:0]    mode;
    logic [DW-1:0] dwell;
    logic [W-1:0]  hold_level;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          step;

    always #5 clk = ~clk;

    pulser_multi #(
        .CHANNELS(CH),
        .WIDTH(W),
        .DWELL_W(DW),
        .START(ST),
        .PHASE(PH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .restart(restart),
        .mode(mode),
        .dwell(dwell),
        .hold_level(hold_level),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .step(step)
    );

    int total = 0;
    int bad   = 0;

    int            m_cnt;
    int            m_dcnt;
    int            m_duty [CH];
    bit            m_up [CH];
    logic [CH-1:0] m_pwm;

    int hi0, hi1, ticks, steps;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_load();
        m_cnt  = 0;
        m_dcnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = (ST + i * PH) % MOD;
            m_up[i]   = 1'b1;
        end
    endtask

    // Triangle as a reflection at the 0 and MAX walls.
    task automatic model_edge(input int pt, input int st);
        int n;
        if (!rst_n) begin
            model_load();
            m_pwm = '0;
        end else begin
            for (int i = 0; i < CH; i++)
                m_pwm[i] = enable && (m_cnt < m_duty[i]);
            if (restart) begin
                model_load();
            end else if (enable) begin
                m_cnt  = (m_cnt + 1) % MOD;
                m_dcnt = (st != 0) ? 0 : (m_dcnt + pt) % (1 << DW);
                for (int i = 0; i < CH; i++) begin
                    if (mode[1]) begin
                        m_duty[i] = int'(hold_level);
                    end else if (st != 0 && mode == 2'b01) begin
                        m_duty[i] = (m_duty[i] + 1) % MOD;
                    end else if (st != 0) begin
                        n = m_duty[i] + (m_up[i] ? 1 : -1);
                        if (n > MAXV) begin
                            n = 2 * MAXV - n;
                            m_up[i] = 1'b0;
                        end else if (n < 0) begin
                            n = -n;
                            m_up[i] = 1'b1;
                        end
                        m_duty[i] = n;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        int pt, st;
        @(negedge clk);
        pt = int'(enable && (m_cnt == MAXV));
        st = int'((pt != 0) && (m_dcnt == int'(dwell)));
        chk("period_tick", 32'(period_tick), 32'(pt));
        chk("step", 32'(step), 32'(st));
        @(posedge clk);
        model_edge(pt, st);
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        hi0   += int'(pwm_out[0]);
        hi1   += int'(pwm_out[1]);
        ticks += pt;
        steps += st;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        hi0 = 0; hi1 = 0; ticks = 0; steps = 0;
    endtask

    initial begin
        int found;
        rst_n = 1'b0; enable = 1'b0; restart = 1'b0;
        mode = 2'b00; dwell = '0; hold_level = '0;
        model_load();
        m_pwm = '0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        chk("reset_step", 32'(step), 32'd0);

        rst_n = 1'b1; enable = 1'b1;
        run(16);
        chk("first_hi0", 32'(hi0), 32'd1);
        chk("first_hi1", 32'(hi1), 32'd9);
        chk("first_ticks", 32'(ticks), 32'd1);
        run(464);
        clr();
        run(16);
        chk("tri_cycle_hi0", 32'(hi0), 32'd1);

        enable = 1'b0; dwell = 10'd2;
        run(1);
        enable = 1'b1;
        clr();
        run(144);
        chk("dwell_ticks", 32'(ticks), 32'd9);
        chk("dwell_steps", 32'(steps), 32'd3);

        enable = 1'b0; dwell = '0;
        run(1);
        enable = 1'b1; mode = 2'b01;
        run(640);

        run(7);
        mode = 2'b10; hold_level = 4'd5;
        run(1);
        mode = 2'b00;
        run(80);

        run(5);
        enable = 1'b0;
        clr();
        run(37);
        chk("off_ticks", 32'(ticks), 32'd0);
        chk("off_steps", 32'(steps), 32'd0);
        chk("off_hi", 32'(hi0 + hi1), 32'd0);
        enable = 1'b1;
        run(50);

        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (m_cnt == MAXV && m_dcnt == int'(dwell)) found = 1;
            else tick();
        end
        chk("restart_align", 32'(found), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        clr();
        run(16);
        chk("restart_hi0", 32'(hi0), 32'd1);
        chk("restart_hi1", 32'(hi1), 32'd9);

        run(5);
        rst_n = 1'b0; mode = 2'b01; restart = 1'b1;
        tick();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        rst_n = 1'b1; restart = 1'b0; mode = 2'b00;
        clr();
        run(16);
        chk("rst_hi0", 32'(hi0), 32'd1);
        chk("rst_hi1", 32'(hi1), 32'd9);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) mode = 2'($urandom);
            if ($urandom_range(9) == 0) hold_level = 4'($urandom);
            restart = ($urandom_range(199) == 0);
            rst_n = ($urandom_range(299) != 0);
            if ($urandom_range(59) == 0) begin
                enable = 1'b0;
                dwell = 10'($urandom_range(3));
                run(1 + $urandom_range(39));
                enable = 1'b1;
            end
            tick();
        end
        restart = 1'b0; rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
